// File: rtl/example_sdiv_seq_21s_14s.sv
// Iterative signed divider: dout = din0 / din1, rem = din0 % din1, truncating toward zero.
// Radix-2 restoring core, one quotient bit per cycle, ap_start/ap_done multicycle unit.
//
// Handshake: ap_start is sampled only on an edge where ce=1 and ap_idle=1 (IDLE or DONE);
// din0/din1 are captured on that same edge. ap_done is a single-cycle pulse (stretched
// only while ce=0) and dout/rem/div_by_zero are valid from it until the next ap_done.
// ap_start seen while busy (ap_idle=0) is dropped, not queued.
module example_sdiv_seq_21s_14s #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 21,
    parameter int din1_WIDTH = 14,
    parameter int dout_WIDTH = 21,
    parameter int NUM_STAGE  = 22
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero,
    output logic [1:0]            dbg_state
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = $clog2(din0_WIDTH);

    // Elaboration-time sanity on the parameter set.
    if (dout_WIDTH != din0_WIDTH) begin : g_bad_dout
        $error("dout_WIDTH must equal din0_WIDTH");
    end
    if (NUM_STAGE != din0_WIDTH + 1) begin : g_bad_stage
        $error("NUM_STAGE must equal din0_WIDTH+1");
    end
    if (ID < 0) begin : g_bad_id
        $error("ID must be non-negative");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W0-1:0]   quo;      // dividend bits shift out of the top, quotient bits in at the bottom
    logic [W1:0]     prem;     // partial remainder, one bit wider than the divisor
    logic [W1-1:0]   dvs;      // divisor magnitude
    logic            sign_q;
    logic            sign_r;
    logic            zero;

    logic [W0-1:0]   a_mag;
    logic [W1-1:0]   b_mag;
    logic [W1:0]     shifted;
    logic [W1:0]     trial;
    logic            take;
    logic [W0-1:0]   q_signed;
    logic [W1-1:0]   r_signed;

    assign dbg_state = state;

    // Operand magnitudes: an N-bit unsigned value holds 2^(N-1) exactly, so |most-negative| is safe.
    always_comb begin
        a_mag = din0[W0-1] ? (~din0 + 1'b1) : din0;
        b_mag = din1[W1-1] ? (~din1 + 1'b1) : din1;
    end

    // One restoring step plus the final sign fix-up of quotient and remainder.
    always_comb begin
        shifted  = {prem[W1-1:0], quo[W0-1]};
        trial    = shifted - {1'b0, dvs};
        take     = (shifted >= {1'b0, dvs});
        q_signed = sign_q ? (~quo + 1'b1) : quo;
        r_signed = sign_r ? (~prem[W1-1:0] + 1'b1) : prem[W1-1:0];
    end

    // Control FSM and datapath; ce=0 freezes everything, reset overrides ce.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= S_IDLE;
            ap_idle     <= 1'b1;
            ap_done     <= 1'b0;
            dout        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            quo         <= '0;
            prem        <= '0;
            dvs         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero        <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE, S_DONE: begin
                    ap_done <= 1'b0;
                    if (ap_start) begin
                        quo     <= a_mag;
                        dvs     <= b_mag;
                        prem    <= '0;
                        sign_q  <= din0[W0-1] ^ din1[W1-1];
                        sign_r  <= din0[W0-1];
                        zero    <= (din1 == '0);
                        cnt     <= CW'(W0 - 1);
                        ap_idle <= 1'b0;
                        state   <= S_CALC;
                    end else begin
                        ap_idle <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_CALC: begin
                    prem <= take ? trial : shifted;
                    quo  <= {quo[W0-2:0], take};
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor leaves an all-ones quotient in the core; report zeros instead.
                    dout        <= zero ? '0 : q_signed;
                    rem         <= zero ? '0 : r_signed;
                    div_by_zero <= zero;
                    ap_done     <= 1'b1;
                    ap_idle     <= 1'b1;
                    state       <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_example_sdiv_seq_21s_14s.sv
// Testbench for example_sdiv_seq_21s_14s: directed scenarios plus a random sweep
// against a plain-arithmetic C-semantics reference model.
module tb_example_sdiv_seq_21s_14s;

  logic               ap_clk;
  logic               ap_rst;
  logic               ce;
  logic               ap_start;
  logic signed [20:0] din0;
  logic signed [13:0] din1;
  logic               ap_idle;
  logic               ap_done;
  logic        [20:0] dout;
  logic        [13:0] rem;
  logic               div_by_zero;
  logic        [1:0]  dbg_state;

  int n_pass;
  int n_total;

  logic [20:0] exp_q[$];
  logic [13:0] exp_r_q[$];
  logic        exp_z_q[$];

  example_sdiv_seq_21s_14s dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ce          (ce),
    .ap_start    (ap_start),
    .din0        (din0),
    .din1        (din1),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .dout        (dout),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // reference model: C division truncating toward zero, quotient wrapped to 21 bits
  function automatic void model(input int a, input int b,
                                output logic [20:0] q, output logic [13:0] r, output logic z);
    int qi;
    int ri;
    if (b == 0) begin
      q = '0;
      r = '0;
      z = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
      q  = qi[20:0];
      r  = ri[13:0];
      z  = 1'b0;
    end
  endfunction

  // driver: issue one op from idle, return edges from accept to ap_done (100 = timeout)
  task automatic run_op(input logic signed [20:0] a, input logic signed [13:0] b, output int lat);
    @(negedge ap_clk);
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    lat = 0;
    while (!ap_done && lat < 100) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    ce = 1'b1;
    ap_start = 1'b0;
    din0 = '0;
    din1 = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    n_total++;
    if ({ap_idle, ap_done, div_by_zero} !== 3'b100 || dout !== 21'd0 || rem !== 14'd0)
      $display("FAIL reset_state: idle=%b done=%b dbz=%b dout=%0d rem=%0d, want idle=1 done=0 dbz=0 dout=0 rem=0",
               ap_idle, ap_done, div_by_zero, dout, rem);
    else n_pass++;
  endtask

  task automatic test_directed();
    int lat;
    logic signed [20:0] a_tab[5] = '{21'sd1000, -21'sd1000, -21'sd1048576, 21'sd5, 21'sd6};
    logic signed [13:0] b_tab[5] = '{-14'sd7, 14'sd7, -14'sd8192, 14'sd0, 14'sd3};
    logic [20:0] q_tab[5] = '{-21'sd142, -21'sd142, 21'sd128, 21'sd0, 21'sd2};
    logic [13:0] r_tab[5] = '{14'sd6, -14'sd6, 14'sd0, 14'sd0, 14'sd0};
    logic        z_tab[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_op(a_tab[i], b_tab[i], lat);
      n_total++;
      if (lat !== 22) $display("FAIL directed_latency[%0d]: got %0d edges, want 22", i, lat);
      else n_pass++;
      n_total++;
      if (dout !== q_tab[i] || rem !== r_tab[i] || div_by_zero !== z_tab[i])
        $display("FAIL directed_result[%0d] %0d/%0d: dout=%0d rem=%0d dbz=%b, want dout=%0d rem=%0d dbz=%b",
                 i, a_tab[i], b_tab[i], $signed(dout), $signed(rem), div_by_zero,
                 $signed(q_tab[i]), $signed(r_tab[i]), z_tab[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic signed [20:0] a_tab[5] = '{-21'sd1048576, 21'sd1000, 21'sd5, 21'sd6, -21'sd1};
    logic signed [13:0] b_tab[5] = '{-14'sd1, -14'sd7, 14'sd0, 14'sd3, 14'sd2};
    logic [20:0] q;
    logic [13:0] r;
    logic        z;
    logic [20:0] eq;
    logic [13:0] er;
    logic        ez;
    for (int i = 0; i < 5; i++) begin
      model(int'(a_tab[i]), int'(b_tab[i]), q, r, z);
      exp_q.push_back(q);
      exp_r_q.push_back(r);
      exp_z_q.push_back(z);
    end
    @(negedge ap_clk);
    din0 = a_tab[0];
    din1 = b_tab[0];
    ap_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      ap_start = 1'b0;
      lat = 0;
      while (!ap_done && lat < 100) begin
        @(posedge ap_clk);
        lat++;
        @(negedge ap_clk);
      end
      eq = exp_q.pop_front();
      er = exp_r_q.pop_front();
      ez = exp_z_q.pop_front();
      n_total++;
      if (lat !== 22) $display("FAIL b2b_latency[%0d]: got %0d edges, want 22", i, lat);
      else n_pass++;
      n_total++;
      if (dout !== eq || rem !== er || div_by_zero !== ez || ap_idle !== 1'b1)
        $display("FAIL b2b_result[%0d]: dout=%0d rem=%0d dbz=%b idle=%b, want dout=%0d rem=%0d dbz=%b idle=1",
                 i, $signed(dout), $signed(rem), div_by_zero, ap_idle, $signed(eq), $signed(er), ez);
      else n_pass++;
      if (i < 4) begin
        din0 = a_tab[i + 1];
        din1 = b_tab[i + 1];
        ap_start = 1'b1;
      end
    end
  endtask

  task automatic test_ce_stall();
    int lat;
    int extra_done;
    @(negedge ap_clk);
    din0 = 21'sd1000;
    din1 = -14'sd7;
    ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    lat = 0;
    repeat (5) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
    end
    n_total++;
    if (ap_idle !== 1'b0) $display("FAIL busy_idle: ap_idle=%b mid-calculation, want 0", ap_idle);
    else n_pass++;
    // stall with start pulses and different operands
    ce = 1'b0;
    din0 = 21'sd7;
    din1 = 14'sd1;
    repeat (5) begin
      ap_start = ~ap_start;
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
    end
    ce = 1'b1;
    ap_start = 1'b1;
    repeat (3) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
    end
    ap_start = 1'b0;
    while (!ap_done && lat < 120) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
    end
    n_total++;
    if (lat !== 27) $display("FAIL ce_latency: got %0d edges, want 27", lat);
    else n_pass++;
    n_total++;
    if (dout !== 21'h1fff72 || rem !== 14'd6 || div_by_zero !== 1'b0)
      $display("FAIL ce_result: dout=%0d rem=%0d dbz=%b, want dout=-142 rem=6 dbz=0",
               $signed(dout), $signed(rem), div_by_zero);
    else n_pass++;
    // freeze while ap_done is high: pulse must stretch
    ce = 1'b0;
    repeat (3) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      n_total++;
      if (ap_done !== 1'b1 || dout !== 21'h1fff72)
        $display("FAIL ce_hold_done: done=%b dout=%0d, want done=1 dout=-142", ap_done, $signed(dout));
      else n_pass++;
    end
    ce = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    n_total++;
    if (ap_done !== 1'b0) $display("FAIL done_pulse: done=%b one cycle after release, want 0", ap_done);
    else n_pass++;
    extra_done = 0;
    repeat (30) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (ap_done) extra_done++;
    end
    n_total++;
    if (extra_done !== 0) $display("FAIL no_queue: %0d extra ap_done cycles, want 0", extra_done);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    run_op(21'sd1000, -14'sd7, lat);
    @(negedge ap_clk);
    din0 = -21'sd999;
    din1 = 14'sd5;
    ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (10) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    n_total++;
    if ({ap_idle, ap_done, div_by_zero} !== 3'b100 || dout !== 21'd0 || rem !== 14'd0)
      $display("FAIL abort_state: idle=%b done=%b dbz=%b dout=%0d rem=%0d, want 1/0/0/0/0",
               ap_idle, ap_done, div_by_zero, $signed(dout), $signed(rem));
    else n_pass++;
    seen = 0;
    repeat (40) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (ap_done) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL abort_no_done: %0d ap_done cycles after reset, want 0", seen);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    int mode;
    logic signed [20:0] a;
    logic signed [13:0] b;
    logic [20:0] q;
    logic [13:0] r;
    logic        z;
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 9);
      a = 21'($urandom);
      if ($urandom_range(0, 15) == 0) a = -21'sd1048576;
      case (mode)
        0: b = '0;
        1: b = 14'($urandom_range(1, 16));
        2: b = -14'($urandom_range(1, 16));
        3: b = -14'sd1;
        4: b = -14'sd8192;
        default: b = 14'($urandom);
      endcase
      model(int'(a), int'(b), q, r, z);
      run_op(a, b, lat);
      n_total++;
      if (lat !== 22 || dout !== q || rem !== r || div_by_zero !== z)
        $display("FAIL random[%0d] %0d/%0d: lat=%0d dout=%0d rem=%0d dbz=%b, want lat=22 dout=%0d rem=%0d dbz=%b",
                 i, a, b, lat, $signed(dout), $signed(rem), div_by_zero, $signed(q), $signed(r), z);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ce_stall();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
